vga_sync_rx: RTL and testbench

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_sync_rx.sv | 219 +++++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel position and lock state from VGA syncs.
// Define VGA_SYNC_RX_ERRCNT_EN to add the o_ErrCount error counter.
module vga_sync_rx #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_SYNC_START = 704,
  parameter int V_SYNC_START = 523,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_HSync,
  input  logic        i_VSync,
  output logic [10:0] o_HPos,
  output logic [10:0] o_VPos,
  output logic        o_Active,
  output logic        o_Locked,
  output logic        o_FrameStart
`ifdef VGA_SYNC_RX_ERRCNT_EN
  ,
  output logic [7:0]  o_ErrCount
`endif
);

  localparam int GW =
    (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [10:0] HMAX   = 11'(H_TOTAL - 1);
  localparam logic [10:0] VMAX   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HSS    = 11'(H_SYNC_START);
  localparam logic [10:0] VSS    = 11'(V_SYNC_START);
  localparam logic [10:0] HACT   = 11'(H_ACTIVE);
  localparam logic [10:0] VACT   = 11'(V_ACTIVE);
  localparam logic [10:0] VLINES = 11'(V_TOTAL);
  localparam logic [11:0] HPER   = 12'(H_TOTAL);
  localparam logic [11:0] TOUT   = 12'(2 * H_TOTAL);
  localparam logic [GW-1:0] LOCKN = GW'(LOCK_FRAMES);

  logic hs_meta_q, hs_sync_q, hs_dly_q, hs_fall_q;
  logic vs_meta_q, vs_sync_q, vs_dly_q, vs_fall_q;

  logic [10:0]   hpos_q, hpos_d;
  logic [10:0]   vpos_q, vpos_d;
  logic [11:0]   per_q, per_d;
  logic          h_seen_q, h_seen_d;
  logic [10:0]   lines_q, lines_d;
  logic          v_seen_q, v_seen_d;
  logic          lerr_q, lerr_d;
  logic [GW-1:0] good_q, good_d;
  logic          lock_q, lock_d;
  logic          active_q, active_d;
  logic          fs_q, fs_d;

  logic h_wrap;
  logic line_err;
  logic frame_err;
  logic good_frame;
  logic any_err;

  // Synchronize both syncs and flag each falling edge one cycle later.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hs_meta_q <= 1'b1;
      hs_sync_q <= 1'b1;
      hs_dly_q  <= 1'b1;
      hs_fall_q <= 1'b0;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_dly_q  <= 1'b1;
      vs_fall_q <= 1'b0;
    end else begin
      hs_meta_q <= i_HSync;
      hs_sync_q <= hs_meta_q;
      hs_dly_q  <= hs_sync_q;
      hs_fall_q <= hs_dly_q & ~hs_sync_q;
      vs_meta_q <= i_VSync;
      vs_sync_q <= vs_meta_q;
      vs_dly_q  <= vs_sync_q;
      vs_fall_q <= vs_dly_q & ~vs_sync_q;
    end
  end

  // Position flywheel, timing measurement and lock qualification.
  always_comb begin
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    per_d      = per_q;
    h_seen_d   = h_seen_q;
    lines_d    = lines_q;
    v_seen_d   = v_seen_q;
    lerr_d     = lerr_q;
    good_d     = good_q;
    lock_d     = lock_q;
    h_wrap     = 1'b0;
    line_err   = 1'b0;
    frame_err  = 1'b0;
    good_frame = 1'b0;

    if (hs_fall_q) begin
      hpos_d = HSS;
    end else if (hpos_q == HMAX) begin
      hpos_d = '0;
      h_wrap = 1'b1;
    end else begin
      hpos_d = hpos_q + 11'd1;
    end

    if (vs_fall_q) begin
      vpos_d = VSS;
    end else if (h_wrap) begin
      vpos_d = (vpos_q == VMAX) ? '0 : vpos_q + 11'd1;
    end

    if (hs_fall_q) begin
      line_err = h_seen_q & (per_q != HPER);
      per_d    = 12'd1;
      h_seen_d = 1'b1;
    end else begin
      if (per_q != '1) begin
        per_d = per_q + 12'd1;
      end
      if (h_seen_q && per_q == TOUT) begin
        line_err = 1'b1;
        h_seen_d = 1'b0;
      end
    end

    if (vs_fall_q) begin
      if (v_seen_q) begin
        frame_err  = (lines_q != VLINES);
        good_frame = ~frame_err & ~lerr_q & ~line_err;
      end
      lines_d  = hs_fall_q ? 11'd1 : 11'd0;
      v_seen_d = 1'b1;
      lerr_d   = 1'b0;
    end else begin
      if (hs_fall_q && lines_q != '1) begin
        lines_d = lines_q + 11'd1;
      end
      lerr_d = lerr_q | line_err;
    end

    any_err = line_err | frame_err;

    if (any_err) begin
      good_d = '0;
      lock_d = 1'b0;
    end else if (good_frame) begin
      if (good_q != LOCKN) begin
        good_d = good_q + 1'b1;
      end
      lock_d = (good_d == LOCKN);
    end

    active_d = lock_d & (hpos_d < HACT) & (vpos_d < VACT);
    fs_d     = lock_d & (hpos_d == '0) & (vpos_d == '0);
  end

  // State registers for position, measurement and outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hpos_q   <= '0;
      vpos_q   <= '0;
      per_q    <= '0;
      h_seen_q <= 1'b0;
      lines_q  <= '0;
      v_seen_q <= 1'b0;
      lerr_q   <= 1'b0;
      good_q   <= '0;
      lock_q   <= 1'b0;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      per_q    <= per_d;
      h_seen_q <= h_seen_d;
      lines_q  <= lines_d;
      v_seen_q <= v_seen_d;
      lerr_q   <= lerr_d;
      good_q   <= good_d;
      lock_q   <= lock_d;
      active_q <= active_d;
      fs_q     <= fs_d;
    end
  end

  assign o_HPos       = hpos_q;
  assign o_VPos       = vpos_q;
  assign o_Active     = active_q;
  assign o_Locked     = lock_q;
  assign o_FrameStart = fs_q;

`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Saturating count of line and frame errors since reset.
  always_comb begin
    errcnt_d = errcnt_q;
    if (any_err && errcnt_q != 8'hFF) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign o_ErrCount = errcnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: randomized sync generator with event-level model.
// Scoreboard queue holds expected outputs tagged with their cycle.
module tb_vga_sync_rx;

  localparam int HT    = 40;
  localparam int VT    = 20;
  localparam int HA    = 32;
  localparam int VA    = 15;
  localparam int HSS   = 35;
  localparam int VSS   = 18;
  localparam int HSW   = 4;
  localparam int LF    = 2;
  localparam int LAT   = 4;
  localparam int FRAME = HT * (VT + 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        act;
  logic        lck;
  logic        fs;
`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0]  ecnt;
`endif

  vga_sync_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT),
    .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_START(HSS), .V_SYNC_START(VSS),
    .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_HSync(hs),
    .i_VSync(vs),
    .o_HPos(hpos),
    .o_VPos(vpos),
    .o_Active(act),
    .o_Locked(lck),
    .o_FrameStart(fs)
`ifdef VGA_SYNC_RX_ERRCNT_EN
    ,
    .o_ErrCount(ecnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tag;
    bit lock;
    int uh;
    int uv;
    bit pos_ok;
    int ecnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // generator state
  int uh, uv, frame_len, pert_line, dl, drop_line, drop_cnt;
  int since_pert;
  bit pert_frame, allow, stress;

  // reference model state (event timestamps)
  bit m_phs, m_pvs, m_hseen, m_vseen, m_lef, m_lock;
  int m_thl, m_lines, m_good, m_ecnt;

  task automatic pick_frame();
    int k;
    frame_len  = VT;
    pert_line  = -1;
    dl         = 0;
    drop_line  = -1;
    pert_frame = 0;
    if (allow) begin
      k = $urandom_range(0, 9);
      case (k)
        5: begin pert_line = $urandom_range(1, 15); dl = 1; end
        6: begin pert_line = $urandom_range(1, 15); dl = -1; end
        7: frame_len = VT - 1;
        8: frame_len = VT + 1;
        9: drop_line = $urandom_range(1, 10);
        default: ;
      endcase
      pert_frame = (k >= 5);
    end
  endtask

  task automatic model_step();
    bit hf, vf, err, ferr, good;
    if (!rst_n) begin
      m_phs = 1; m_pvs = 1; m_hseen = 0; m_vseen = 0;
      m_lef = 0; m_lock = 0; m_thl = 0; m_lines = 0;
      m_good = 0; m_ecnt = 0;
      return;
    end
    hf = m_phs && !hs;
    vf = m_pvs && !vs;
    m_phs = hs;
    m_pvs = vs;
    err = 0; ferr = 0; good = 0;
    if (hf) begin
      if (m_hseen && (cyc - m_thl) != HT) err = 1;
      m_hseen = 1;
      m_thl = cyc;
    end else if (m_hseen && (cyc - m_thl) == 2 * HT) begin
      err = 1;
      m_hseen = 0;
    end
    if (vf) begin
      if (m_vseen) begin
        ferr = (m_lines != VT);
        good = !ferr && !m_lef && !err;
      end
      m_vseen = 1;
      m_lef = 0;
      m_lines = hf ? 1 : 0;
    end else begin
      m_lines += hf ? 1 : 0;
      m_lef = m_lef | err;
    end
    if (err || ferr) begin
      m_good = 0;
      m_lock = 0;
      if (m_ecnt < 255) m_ecnt++;
    end else if (good) begin
      if (m_good < LF) m_good++;
      m_lock = (m_good >= LF);
    end
  endtask

  task automatic gen_step();
    int llen;
    exp_t e;
    hs = (drop_cnt > 0) ? 1'b1 : !(uh >= HSS && uh < HSS + HSW);
    vs = !(uv >= VSS);
    if (!rst_n || pert_frame || stress) since_pert = 0;
    else since_pert++;
    model_step();
    e.tag    = cyc + LAT;
    e.lock   = m_lock;
    e.uh     = uh;
    e.uv     = uv;
    e.pos_ok = m_lock && since_pert >= 2 * FRAME;
    e.ecnt   = m_ecnt;
    sb.push_back(e);
    if (drop_cnt > 0) drop_cnt--;
    llen = stress ? HT + 1 : ((uv == pert_line) ? HT + dl : HT);
    if (uh >= llen - 1) begin
      uh = 0;
      if (uv >= frame_len - 1) begin
        uv = 0;
        pick_frame();
      end else begin
        uv++;
      end
      if (uv == drop_line) drop_cnt = 2 * HT + 5;
    end else begin
      uh++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gen_step();
    end
  endtask

  // monitor: compare DUT outputs against the tagged expectations
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag < cyc) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].tag == cyc) begin
        e = sb.pop_front();
        chk("locked", int'(lck), int'(e.lock));
        if (!e.lock) begin
          chk("active_unlocked", int'(act), 0);
          chk("framestart_unlocked", int'(fs), 0);
        end else if (e.pos_ok) begin
          chk("hpos", int'(hpos), e.uh);
          chk("vpos", int'(vpos), e.uv);
          chk("active", int'(act), int'(e.uh < HA && e.uv < VA));
          chk("framestart", int'(fs), int'(e.uh == 0 && e.uv == 0));
        end
`ifdef VGA_SYNC_RX_ERRCNT_EN
        chk("errcount", int'(ecnt), e.ecnt);
`endif
      end
    end
  end

  initial begin
    uh = 0; uv = 5; drop_cnt = 0; since_pert = 0;
    allow = 0; stress = 0;
    pick_frame();
    rst_n = 1'b0;
    run(8);
    chk("rst_hpos", int'(hpos), 0);
    chk("rst_vpos", int'(vpos), 0);
    chk("rst_locked", int'(lck), 0);
    chk("rst_active", int'(act), 0);
    chk("rst_framestart", int'(fs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    gen_step();
    run(5 * FRAME);
    allow = 1;
    run(40 * FRAME);
    allow = 0;
    run(uh < 20 ? 20 - uh : 60 - uh);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    run(6);
    @(negedge clk);
    rst_n = 1'b1;
    gen_step();
    run(5 * FRAME);
`ifdef VGA_SYNC_RX_ERRCNT_EN
    stress = 1;
    run(17 * FRAME);
    stress = 0;
    run(LAT + 2);
    chk("errcount_saturated", int'(ecnt), 255);
`endif
    run(LAT + 4);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
